ysyx_22040759_axi_rd_mux: RTL and testbench

// - N-client AXI4 read arbiter and burst read master. Generalises the fixed two-client (IF/MEM), single-beat read path.
// - Accepts burst read requests from NUM_REQ clients (IF, MEM, future DMA/cache refill) and grants one at a time, round-robin or fixed-priority.
// - Drives one AXI AR/R channel pair and steers each R beat back to the granted client. Checks beat count and ID.

---
 rtl/ysyx_22040759_axi_rd_mux_pkg.sv | 17 +
 rtl/ysyx_22040759_axi_rd_mux_if.sv | 40 ++++
 rtl/ysyx_22040759_rr_arbiter.sv | 36 +++
 rtl/ysyx_22040759_axi_rd_mux.sv | 171 +++++++++++++++++
 tb/tb_ysyx_22040759_axi_rd_mux.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040759_axi_rd_mux_pkg.sv
// rtl/ysyx_22040759_axi_rd_mux_pkg.sv - shared FSM states and AXI encodings for the read mux
package ysyx_22040759_axi_rd_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_22040759_axi_rd_mux_if.sv
// rtl/ysyx_22040759_axi_rd_mux_if.sv - AXI4 read address / read data channel bundle
interface ysyx_22040759_axi_rd_mux_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
);

  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0]   ar_id;
  logic [LEN_W-1:0]  ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [2:0]        ar_prot;
  logic [3:0]        ar_cache;
  logic              ar_lock;
  logic [3:0]        ar_qos;

  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [ID_W-1:0]   r_id;

  modport master (
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
           ar_prot, ar_cache, ar_lock, ar_qos, r_ready,
    input  ar_ready, r_valid, r_data, r_resp, r_last, r_id
  );

  modport slave (
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
           ar_prot, ar_cache, ar_lock, ar_qos, r_ready,
    output ar_ready, r_valid, r_data, r_resp, r_last, r_id
  );

endinterface

// File: rtl/ysyx_22040759_rr_arbiter.sv
// rtl/ysyx_22040759_rr_arbiter.sv - round-robin / fixed-priority one-hot request arbiter
module ysyx_22040759_rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int PRIO_MODE = 0,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;

  // Walk candidates starting at the pointer (or at 0 in fixed mode); first requester wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PRIO_MODE != 0) begin
        cand = IDX_W'(i);
      end else begin
        cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      end
      if (!valid_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_22040759_axi_rd_mux.sv
// rtl/ysyx_22040759_axi_rd_mux.sv - N-client AXI4 burst read arbiter and master
module ysyx_22040759_axi_rd_mux
  import ysyx_22040759_axi_rd_mux_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*3-1:0]      req_size_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_last_o,
  output logic [1:0]                rsp_resp_o,
  output logic                      err_o,
  ysyx_22040759_axi_rd_mux_if.master axi
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic                cnt_zero;

  ysyx_22040759_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .PRIO_MODE(PRIO_MODE),
    .IDX_W    (IDX_W)
  ) u_arb (
    .req_i  (req_valid_i),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  assign cnt_zero = (cnt_q == '0);

  // Next-state and datapath: grant in IDLE, hold AR until accepted, forward and check R beats.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    size_d      = size_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          idx_d       = arb_idx;
          addr_d      = req_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
          size_d      = req_size_i[int'(arb_idx)*3 +: 3];
          len_d       = req_len_i[int'(arb_idx)*LEN_W +: LEN_W];
          req_ready_d = arb_gnt;
          ptr_d       = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d     = ST_AR;
        end
      end
      ST_AR: begin
        if (axi.ar_ready) begin
          cnt_d   = len_q;
          state_d = ST_R;
        end
      end
      ST_R: begin
        if (axi.r_valid) begin
          rsp_valid_d[idx_q] = 1'b1;
          rsp_data_d         = axi.r_data;
          rsp_resp_d         = axi.r_resp;
          // A missing RLAST still closes the burst so the client sees a terminated transfer.
          rsp_last_d         = axi.r_last | cnt_zero;
          if (axi.r_last != cnt_zero) begin
            err_d = 1'b1;
          end
          if (axi.r_id != ID_W'(idx_q)) begin
            err_d = 1'b1;
          end
          if (axi.r_last || cnt_zero) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; async reset drops ARVALID/RREADY immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_last_o   = rsp_last_q;
  assign rsp_resp_o   = rsp_resp_q;
  assign err_o        = err_q;

  assign axi.ar_valid = (state_q == ST_AR);
  assign axi.ar_addr  = addr_q;
  assign axi.ar_id    = ID_W'(idx_q);
  assign axi.ar_len   = len_q;
  assign axi.ar_size  = size_q;
  assign axi.ar_burst = AXI_BURST_INCR;
  assign axi.ar_prot  = 3'b000;
  assign axi.ar_cache = 4'b0000;
  assign axi.ar_lock  = 1'b0;
  assign axi.ar_qos   = 4'b0000;
  assign axi.r_ready  = (state_q == ST_R);

endmodule

// File: tb/tb_ysyx_22040759_axi_rd_mux.sv
// tb/tb_ysyx_22040759_axi_rd_mux.sv - randomized self-checking bench for the AXI read mux
module tb_ysyx_22040759_axi_rd_mux;
  import ysyx_22040759_axi_rd_mux_pkg::*;

  localparam int N  = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int LW = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*3-1:0]  req_size;
  logic [N*LW-1:0] req_len;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last, err;
  logic [1:0]      rsp_resp;

  logic [N-1:0]    req_valid_p, req_ready_p, rsp_valid_p;
  logic [N*AW-1:0] req_addr_p;
  logic [N*3-1:0]  req_size_p;
  logic [N*LW-1:0] req_len_p;
  logic [DW-1:0]   rsp_data_p;
  logic            rsp_last_p, err_p;
  logic [1:0]      rsp_resp_p;

  ysyx_22040759_axi_rd_mux_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) axi_m ();
  ysyx_22040759_axi_rd_mux_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) axi_p ();

  ysyx_22040759_axi_rd_mux #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW), .PRIO_MODE(0)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_size_i(req_size), .req_len_i(req_len),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_last_o(rsp_last),
    .rsp_resp_o(rsp_resp), .err_o(err), .axi(axi_m)
  );

  ysyx_22040759_axi_rd_mux #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW), .PRIO_MODE(1)
  ) dut_p (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_p), .req_ready_o(req_ready_p), .req_addr_i(req_addr_p),
    .req_size_i(req_size_p), .req_len_i(req_len_p),
    .rsp_valid_o(rsp_valid_p), .rsp_data_o(rsp_data_p), .rsp_last_o(rsp_last_p),
    .rsp_resp_o(rsp_resp_p), .err_o(err_p), .axi(axi_p)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state: RR pointer, sticky error, per-client pending request fields
  int          m_ptr;
  logic        m_err;
  logic [AW-1:0] c_addr [N];
  int          c_len  [N];
  int          c_size [N];
  bit          use_force;
  logic [DW-1:0] force_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int model_winner(input logic [N-1:0] v, input int ptr, input bit prio);
    for (int i = 0; i < N; i++) begin
      int k;
      k = prio ? i : (ptr + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic add_req(input int k, input logic [AW-1:0] a, input int len, input int sz);
    c_addr[k] = a;
    c_len[k]  = len;
    c_size[k] = sz;
    req_addr[k*AW +: AW] = a;
    req_len[k*LW +: LW]  = LW'(len);
    req_size[k*3 +: 3]   = 3'(sz);
    req_valid[k]         = 1'b1;
  endtask

  task automatic clear_r();
    axi_m.r_valid = 1'b0;
    axi_m.r_last  = 1'b0;
    axi_m.r_data  = '0;
    axi_m.r_resp  = '0;
    axi_m.r_id    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_r();
    axi_m.ar_ready = 1'b0;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    m_ptr = 0;
    m_err = 1'b0;
  endtask

  // inj: 0 none, 1 early RLAST at inj_beat, 2 no RLAST on final beat, 3 wrong RID
  task automatic run_burst(input int ar_wait, input int inj, input int inj_beat,
                           input logic [1:0] resp_at, input int resp_beat,
                           input bit rst_mid, output int win);
    int w, t, nb;
    logic [N-1:0] oh;
    w = model_winner(req_valid, m_ptr, 1'b0);
    win = w;
    t = 0;
    do begin
      tick();
      t++;
    end while (req_ready == '0 && t < 20);
    oh = '0;
    if (w >= 0) oh[w] = 1'b1;
    chk("req_ready_grant", 64'(req_ready), 64'(oh));
    if (req_ready == '0 || w < 0) return;
    chk("ar_valid", 64'(axi_m.ar_valid), 64'(1));
    chk("ar_addr", 64'(axi_m.ar_addr), 64'(c_addr[w]));
    chk("ar_id", 64'(axi_m.ar_id), 64'(w));
    chk("ar_len", 64'(axi_m.ar_len), 64'(c_len[w]));
    chk("ar_size", 64'(axi_m.ar_size), 64'(c_size[w]));
    chk("ar_burst", 64'(axi_m.ar_burst), 64'(1));
    req_valid[w] = 1'b0;
    m_ptr = (w + 1) % N;
    for (int i = 0; i < ar_wait; i++) begin
      tick();
      chk("ar_hold_valid", 64'(axi_m.ar_valid), 64'(1));
      chk("ar_hold_addr", 64'(axi_m.ar_addr), 64'(c_addr[w]));
    end
    axi_m.ar_ready = 1'b1;
    tick();
    axi_m.ar_ready = 1'b0;
    chk("req_ready_pulse", 64'(req_ready), 64'(0));
    chk("ar_done", 64'(axi_m.ar_valid), 64'(0));
    nb = c_len[w] + 1;
    for (int b = 0; b < nb; b++) begin
      logic lst, berr;
      logic [DW-1:0] d;
      logic [1:0] rs;
      logic [IW-1:0] id;
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("rsp_gap_idle", 64'(rsp_valid), 64'(0));
      end
      chk("r_ready", 64'(axi_m.r_ready), 64'(1));
      d   = (use_force && b == 0) ? force_data : {$urandom, $urandom};
      lst = (b == nb - 1);
      if (inj == 1 && b == inj_beat) lst = 1'b1;
      if (inj == 2 && b == nb - 1) lst = 1'b0;
      id  = (inj == 3) ? IW'(w ^ 3) : IW'(w);
      rs  = (b == resp_beat) ? resp_at : RESP_OKAY;
      axi_m.r_valid = 1'b1;
      axi_m.r_data  = d;
      axi_m.r_last  = lst;
      axi_m.r_resp  = rs;
      axi_m.r_id    = id;
      if (rst_mid && b == 2) begin
        reset = 1'b0;
        #1;
        chk("rst_ar_valid", 64'(axi_m.ar_valid), 64'(0));
        chk("rst_r_ready", 64'(axi_m.r_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        clear_r();
        req_valid = '0;
        m_ptr = 0;
        m_err = 1'b0;
        return;
      end
      tick();
      clear_r();
      berr  = (lst != (b == nb - 1)) || (id != IW'(w));
      m_err = m_err | berr;
      chk("rsp_valid", 64'(rsp_valid), 64'(oh));
      chk("rsp_data", 64'(rsp_data), 64'(d));
      chk("rsp_last", 64'(rsp_last), 64'(lst || (b == nb - 1)));
      chk("rsp_resp", 64'(rsp_resp), 64'(rs));
      chk("err", 64'(err), 64'(m_err));
      if (lst || b == nb - 1) break;
    end
    chk("r_ready_done", 64'(axi_m.r_ready), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, t;
    int rr_exp [4] = '{0, 1, 2, 0};
    req_valid = '0; req_addr = '0; req_size = '0; req_len = '0;
    req_valid_p = '0; req_addr_p = '0; req_size_p = '0; req_len_p = '0;
    axi_m.ar_ready = 1'b0;
    clear_r();
    axi_p.ar_ready = 1'b1;
    axi_p.r_valid = 1'b0; axi_p.r_last = 1'b0; axi_p.r_data = '0;
    axi_p.r_resp = '0; axi_p.r_id = '0;
    use_force = 1'b0; force_data = '0;
    m_ptr = 0; m_err = 1'b0;

    tick();
    tick();
    chk("reset_ar_valid", 64'(axi_m.ar_valid), 64'(0));
    chk("reset_r_ready", 64'(axi_m.r_ready), 64'(0));
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_last", 64'(rsp_last), 64'(0));
    chk("reset_err", 64'(err), 64'(0));
    chk("reset_ar_addr", 64'(axi_m.ar_addr), 64'(0));
    reset = 1'b1;
    tick();

    // round-robin fairness with every client requesting continuously
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N; k++)
        if (!req_valid[k]) add_req(k, {$urandom, $urandom}, $urandom_range(0, 2), 3);
      run_burst(0, 0, 0, RESP_OKAY, -1, 1'b0, w);
      chk("rr_order", 64'(w), 64'(rr_exp[i]));
    end
    while (req_valid != '0) run_burst(0, 0, 0, RESP_OKAY, -1, 1'b0, w);

    // single-beat request from client 1
    use_force = 1'b1; force_data = 64'h0000_0000_DEAD_BEEF;
    add_req(1, 64'h0000_0000_8000_0010, 0, 3);
    run_burst(0, 0, 0, RESP_OKAY, -1, 1'b0, w);
    use_force = 1'b0;

    // four-beat burst with ARREADY held low for five cycles
    add_req(0, 64'h0000_0000_8000_0000, 3, 3);
    run_burst(5, 0, 0, RESP_OKAY, -1, 1'b0, w);

    // randomized mixed traffic, occasional non-OKAY responses
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N; k++)
        if (!req_valid[k] && $urandom_range(0, 1) == 1)
          add_req(k, {$urandom, $urandom}, $urandom_range(0, 5), $urandom_range(0, 3));
      if (req_valid == '0)
        add_req($urandom_range(0, N - 1), {$urandom, $urandom}, $urandom_range(0, 5), 2);
      run_burst($urandom_range(0, 3), 0, 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 5), 1'b0, w);
    end
    while (req_valid != '0) run_burst(0, 0, 0, RESP_OKAY, -1, 1'b0, w);

    // SLVERR mid-burst passes through without flagging an error
    add_req(2, 64'h0000_0000_1000_0000, 3, 3);
    run_burst(1, 0, 0, RESP_SLVERR, 1, 1'b0, w);

    // early RLAST, then a clean burst to show the error is sticky
    add_req(2, 64'h0000_0000_2000_0000, 3, 3);
    run_burst(1, 1, 1, RESP_OKAY, -1, 1'b0, w);
    add_req(0, 64'h0000_0000_2000_0100, 1, 3);
    run_burst(0, 0, 0, RESP_OKAY, -1, 1'b0, w);

    // missing RLAST on the final beat
    do_reset();
    add_req(0, 64'h0000_0000_3000_0000, 1, 2);
    run_burst(0, 2, 0, RESP_OKAY, -1, 1'b0, w);

    // wrong RID for grant 0
    do_reset();
    add_req(0, 64'h0000_0000_4000_0000, 2, 3);
    run_burst(0, 3, 0, RESP_OKAY, -1, 1'b0, w);

    // reset during a len-7 burst, then a lone client 1 request
    do_reset();
    add_req(0, 64'h0000_0000_5000_0000, 7, 3);
    run_burst(0, 0, 0, RESP_OKAY, -1, 1'b1, w);
    tick();
    tick();
    reset = 1'b1;
    add_req(1, 64'h0000_0000_6000_0000, 1, 3);
    run_burst(0, 0, 0, RESP_OKAY, -1, 1'b0, w);
    chk("post_reset_grant", 64'(w), 64'(1));

    // fixed priority: client 0 keeps winning while it keeps requesting
    req_valid_p = '1;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      do begin
        tick();
        t++;
      end while (req_ready_p == '0 && t < 20);
      chk("prio_grant", 64'(req_ready_p), 64'(model_winner(3'b111, i, 1'b1) == 0 ? 1 : 0));
      t = 0;
      while (!axi_p.r_ready && t < 10) begin
        tick();
        t++;
      end
      chk("prio_r_ready", 64'(axi_p.r_ready), 64'(1));
      axi_p.r_valid = 1'b1;
      axi_p.r_last  = 1'b1;
      axi_p.r_data  = 64'(i);
      tick();
      axi_p.r_valid = 1'b0;
      axi_p.r_last  = 1'b0;
      chk("prio_rsp_valid", 64'(rsp_valid_p), 64'(1));
      chk("prio_err", 64'(err_p), 64'(0));
    end
    req_valid_p = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
